// File: rtl/usb_stuff_pkg.sv
// Shared types and defaults for the USB bit-stuffing path.
package usb_stuff_pkg;
  typedef enum logic {STUFF_TX, STUFF_RX} stuff_dir_t;
  localparam int USB_STUFF_RUN_LEN = 6;
endpackage

// File: rtl/run_counter.sv
// Consecutive-ones counter with terminal-count detect for bit_stuff_engine.
module run_counter
  import usb_stuff_pkg::*;
#(
  parameter  int RUN_LEN = USB_STUFF_RUN_LEN,
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  logic [CNT_W-1:0] r_cnt;

  assign hit = inc & (r_cnt == CNT_W'(RUN_LEN - 1));

  // Terminal count folds back to 0 instead of wrapping past RUN_LEN-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc) r_cnt <= hit ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/bit_stuff_engine.sv
// Bidirectional USB bit stuffer/destuffer advanced by the bit-rate strobe.
// Optional RX violation detect: define STUFF_ERR_CHECK_EN.
module bit_stuff_engine
  import usb_stuff_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_strobe,
  input  logic clear,
  input  logic dir,
  input  logic serial_in,
  output logic serial_out,
  output logic consume,
  output logic stuffing,
  output logic stuff_err
);
  typedef enum logic {S_COUNT, S_STUFF} state_t;

  state_t r_state;
  logic   w_pend, w_adv, w_inc, w_clr, w_hit, w_tx;

  assign w_pend = (r_state == S_STUFF);
  assign w_adv  = bit_strobe & ~clear;
  assign w_inc  = w_adv & ~w_pend & serial_in;
  // Stuff slots and data zeros both restart the run.
  assign w_clr  = clear | (w_adv & (w_pend | ~serial_in));
  assign w_tx   = (stuff_dir_t'(dir) == STUFF_TX);

  run_counter #(.RUN_LEN(RUN_LEN)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_inc),
    .clr (w_clr),
    .hit (w_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_COUNT;
    else if (clear) r_state <= S_COUNT;
    else if (bit_strobe) begin
      case (r_state)
        S_COUNT: if (w_hit) r_state <= S_STUFF;
        S_STUFF: r_state <= S_COUNT;
        default: r_state <= S_COUNT;
      endcase
    end
  end

  assign stuffing   = w_pend;
  assign consume    = bit_strobe & ~w_pend & ~clear;
  assign serial_out = (w_tx & w_pend) ? 1'b0 : serial_in;

`ifdef STUFF_ERR_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_adv & w_pend & ~w_tx & serial_in;
  end
  assign stuff_err = r_err;
`else
  assign stuff_err = 1'b0;
`endif
endmodule

// File: tb/tb_bit_stuff_engine.sv
// Directed bench for bit_stuff_engine at RUN_LEN 6, 2 and 15 sharing one stimulus.
module tb_bit_stuff_engine;
  logic clk = 1'b0;
  logic rst, bit_strobe, clear, dir, serial_in;
  logic [2:0] so, cs, st, er;
  logic [2:0] s_so, s_cs, s_st, s_er, s_er2;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bit_stuff_engine #(.RUN_LEN(6)) dut6 (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .clear(clear), .dir(dir),
    .serial_in(serial_in), .serial_out(so[0]), .consume(cs[0]),
    .stuffing(st[0]), .stuff_err(er[0]));
  bit_stuff_engine #(.RUN_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .clear(clear), .dir(dir),
    .serial_in(serial_in), .serial_out(so[1]), .consume(cs[1]),
    .stuffing(st[1]), .stuff_err(er[1]));
  bit_stuff_engine #(.RUN_LEN(15)) dut15 (
    .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .clear(clear), .dir(dir),
    .serial_in(serial_in), .serial_out(so[2]), .consume(cs[2]),
    .stuffing(st[2]), .stuff_err(er[2]));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One strobed bit; outputs captured mid-cycle, stuff_err one and two cycles later.
  task automatic strobe(input logic b, input logic clr, input int gap);
    @(negedge clk);
    serial_in = b; bit_strobe = 1'b1; clear = clr;
    #1;
    s_so = so; s_cs = cs; s_st = st;
    @(negedge clk);
    bit_strobe = 1'b0; clear = 1'b0; serial_in = 1'($urandom);
    #1 s_er = er;
    @(negedge clk);
    #1 s_er2 = er;
    repeat (gap - 3) @(negedge clk);
  endtask

  task automatic resync(input logic d);
    @(negedge clk);
    clear = 1'b1; dir = d;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bit_strobe = 1'b0; clear = 1'($urandom); dir = 1'b1;
    serial_in = 1'($urandom);
    repeat (3) @(negedge clk);
    serial_in = 1'b1; #1;
    check("rst_stuffing", st[0], 1'b0);
    check("rst_err", er[0], 1'b0);
    check("rst_consume", cs[0], 1'b0);
    check("rst_so_rx1", so[0], 1'b1);
    serial_in = 1'b0; #1;
    check("rst_so_rx0", so[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    resync(1'b0);

    // TX: seven ones at the 64-cycle bit rate
    for (int i = 1; i <= 6; i++) begin
      strobe(1'b1, 1'b0, 64);
      check($sformatf("tx1_so_%0d", i), s_so[0], 1'b1);
      check($sformatf("tx1_cs_%0d", i), s_cs[0], 1'b1);
      check($sformatf("tx1_st_%0d", i), s_st[0], 1'b0);
    end
    strobe(1'b1, 1'b0, 64);
    check("tx1_so_7", s_so[0], 1'b0);
    check("tx1_st_7", s_st[0], 1'b1);
    check("tx1_cs_7", s_cs[0], 1'b0);
    strobe(1'b1, 1'b0, 64);
    check("tx1_so_8", s_so[0], 1'b1);
    check("tx1_cs_8", s_cs[0], 1'b1);
    check("tx1_st_8", s_st[0], 1'b0);
    // counter was 1 after strobe 8, so five more ones reach the next slot
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 8);
    check("tx1_cnt1_pre", s_st[0], 1'b0);
    strobe(1'b1, 1'b0, 8);
    check("tx1_cnt1_slot", s_st[0], 1'b1);

    // TX: five ones then a zero never stuff, and the run restarts
    resync(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 8);
    strobe(1'b0, 1'b0, 8);
    check("tx5_st_zero", s_st[0], 1'b0);
    check("tx5_so_zero", s_so[0], 1'b0);
    check("tx5_cs_zero", s_cs[0], 1'b1);
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 8);
    check("tx5_st_6th", s_st[0], 1'b0);
    strobe(1'b1, 1'b0, 8);
    check("tx5_st_slot", s_st[0], 1'b1);

    // RX: 1111110 is a clean stuffed run
    resync(1'b1);
    for (int i = 1; i <= 6; i++) begin
      strobe(1'b1, 1'b0, 8);
      check($sformatf("rx_cs_%0d", i), s_cs[0], 1'b1);
    end
    strobe(1'b0, 1'b0, 8);
    check("rx_cs_stuff", s_cs[0], 1'b0);
    check("rx_st_stuff", s_st[0], 1'b1);
    check("rx_so_stuff", s_so[0], 1'b0);
    check("rx_err_clean", s_er[0], 1'b0);

    // RX: 1111111 is a violation
    resync(1'b1);
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 8);
    strobe(1'b1, 1'b0, 8);
    check("rxv_cs_7", s_cs[0], 1'b0);
    check("rxv_so_7", s_so[0], 1'b1);
`ifdef STUFF_ERR_CHECK_EN
    check("rxv_err_pulse", s_er[0], 1'b1);
`else
    check("rxv_err_tied", s_er[0], 1'b0);
`endif
    check("rxv_err_one_cycle", s_er2[0], 1'b0);
    strobe(1'b1, 1'b0, 8);
    check("rxv_recover_cs", s_cs[0], 1'b1);
    check("rxv_recover_st", s_st[0], 1'b0);

    // RUN_LEN=2 and RUN_LEN=15 in TX
    resync(1'b0);
    strobe(1'b1, 1'b0, 4);
    check("r2_cs_1", s_cs[1], 1'b1);
    strobe(1'b1, 1'b0, 4);
    check("r2_st_2", s_st[1], 1'b0);
    strobe(1'b1, 1'b0, 4);
    check("r2_st_3", s_st[1], 1'b1);
    check("r2_so_3", s_so[1], 1'b0);
    resync(1'b0);
    for (int i = 0; i < 15; i++) strobe(1'b1, 1'b0, 4);
    check("r15_st_15", s_st[2], 1'b0);
    check("r15_so_15", s_so[2], 1'b1);
    strobe(1'b1, 1'b0, 4);
    check("r15_st_16", s_st[2], 1'b1);
    check("r15_cs_16", s_cs[2], 1'b0);

    // clear on the strobe of the 6th one cancels the slot
    resync(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 4);
    strobe(1'b1, 1'b1, 4);
    check("clr_cs_suppress", s_cs[0], 1'b0);
    strobe(1'b1, 1'b0, 4);
    check("clr_no_slot", s_st[0], 1'b0);
    check("clr_cs_next", s_cs[0], 1'b1);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 4);
    check("clr_restart_pre", s_st[0], 1'b0);
    strobe(1'b1, 1'b0, 4);
    check("clr_restart_slot", s_st[0], 1'b1);

    // async reset mid-packet with a slot pending
    resync(1'b0);
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0, 4);
    #2 rst = 1'b1;
    #1 check("arst_st", st[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    strobe(1'b1, 1'b0, 4);
    check("arst_first_cs", s_cs[0], 1'b1);
    check("arst_first_st", s_st[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
